// File: rtl/audio_pkg.sv
// Shared sizing, mode encoding and access-sequencer states for the audio
// sample memory controller.
package audio_pkg;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 262144;
  localparam int LEN_W     = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_WR_SETUP,
    SEQ_WR_STROBE,
    SEQ_RD_1,
    SEQ_RD_2
  } seq_state_e;

endpackage

// File: rtl/sram_access_seq.sv
// SRAM strobe sequencer: a write is one setup cycle then one we_n-low cycle,
// a read holds oe_n low for two cycles; done marks the final cycle of either.
module sram_access_seq
  import audio_pkg::*;
(
  input  logic              bclk,
  input  logic              reset,
  input  logic              start,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              done
);

  seq_state_e state, state_next;

  // Strobes are registered from the next state so they never glitch at the pins.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state      <= SEQ_IDLE;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      state     <= state_next;
      sram_we_n <= (state_next != SEQ_WR_STROBE);
      sram_oe_n <= !((state_next == SEQ_RD_1) || (state_next == SEQ_RD_2));
      if ((state == SEQ_IDLE) && start) begin
        sram_addr <= addr;
        if (!rd) begin
          sram_wdata <= wdata;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE:      if (start) state_next = rd ? SEQ_RD_1 : SEQ_WR_SETUP;
      SEQ_WR_SETUP:  state_next = SEQ_WR_STROBE;
      SEQ_WR_STROBE: state_next = SEQ_IDLE;
      SEQ_RD_1:      state_next = SEQ_RD_2;
      SEQ_RD_2:      state_next = SEQ_IDLE;
      default:       state_next = SEQ_IDLE;
    endcase
  end

  assign busy = (state != SEQ_IDLE);
  assign done = (state == SEQ_WR_STROBE) || (state == SEQ_RD_2);

endmodule

// File: rtl/audio_mem_ctrl.sv
// Record/playback controller streaming 16-bit audio samples through an
// asynchronous SRAM. Define AUDIO_LOOP_PLAY_EN to loop playback until stopped.
module audio_mem_ctrl
  import audio_pkg::*;
(
  input  logic              bclk,
  input  logic              reset,
  input  logic              cmd_rec,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [1:0]        mode,
  output logic [LEN_W-1:0]  rec_len,
  output logic              overrun
);

  mode_e             state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              stop_pending;
  logic              stop_req;
  logic              seq_start, seq_busy, seq_done;
  logic              enter_rec, enter_play, drop;
  logic              last_read, play_exit, play_wrap;

  sram_access_seq u_seq (
    .bclk       (bclk),
    .reset      (reset),
    .start      (seq_start),
    .rd         (state == MODE_PLAY),
    .addr       (ptr),
    .wdata      (adc_data),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .busy       (seq_busy),
    .done       (seq_done)
  );

  assign stop_req  = cmd_stop | stop_pending;
  assign last_read = ({1'b0, ptr} == (rec_len - LEN_W'(1)));

`ifdef AUDIO_LOOP_PLAY_EN
  assign play_exit = 1'b0;
  assign play_wrap = last_read;
`else
  assign play_exit = last_read;
  assign play_wrap = 1'b0;
`endif

  // A stop never cuts an access short: the mode is left only once the
  // sequencer is idle or finishing its last strobe cycle.
  always_comb begin
    state_next = state;
    enter_rec  = 1'b0;
    enter_play = 1'b0;
    seq_start  = 1'b0;
    drop       = 1'b0;
    case (state)
      MODE_IDLE: begin
        if (!cmd_stop) begin
          if (cmd_rec) begin
            state_next = MODE_REC;
            enter_rec  = 1'b1;
          end else if (cmd_play && (rec_len != '0)) begin
            state_next = MODE_PLAY;
            enter_play = 1'b1;
          end
        end
      end
      MODE_REC: begin
        if (adc_valid) begin
          if (seq_busy)       drop      = 1'b1;
          else if (!stop_req) seq_start = 1'b1;
        end
        if (stop_req && (!seq_busy || seq_done))   state_next = MODE_IDLE;
        else if (seq_done && (ptr == ADDR_LAST))   state_next = MODE_IDLE;
      end
      MODE_PLAY: begin
        if (dac_req) begin
          if (seq_busy)       drop      = 1'b1;
          else if (!stop_req) seq_start = 1'b1;
        end
        if (stop_req && (!seq_busy || seq_done)) state_next = MODE_IDLE;
        else if (seq_done && play_exit)          state_next = MODE_IDLE;
      end
      default: state_next = MODE_IDLE;
    endcase
  end

  always_comb begin
    ptr_next = ptr;
    if (enter_rec || enter_play) begin
      ptr_next = '0;
    end else if (seq_done) begin
      ptr_next = ((state == MODE_PLAY) && play_wrap) ? '0 : ptr + ADDR_W'(1);
    end
  end

  // The write landing on the top address fills the memory, so the length
  // saturates at the full depth rather than following the wrapped pointer.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state        <= MODE_IDLE;
      ptr          <= '0;
      rec_len      <= '0;
      overrun      <= 1'b0;
      stop_pending <= 1'b0;
      dac_data     <= '0;
      dac_valid    <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      stop_pending <= stop_req && (state != MODE_IDLE) && (state_next != MODE_IDLE);
      dac_valid    <= seq_done && (state == MODE_PLAY);
      if (seq_done && (state == MODE_PLAY)) begin
        dac_data <= sram_rdata;
      end
      if (enter_rec) begin
        rec_len <= '0;
        overrun <= 1'b0;
      end else begin
        if (seq_done && (state == MODE_REC)) begin
          rec_len <= (ptr == ADDR_LAST) ? LEN_FULL : rec_len + LEN_W'(1);
        end
        if (drop) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign mode = state;

endmodule

// File: doc/audio_mem_ctrl.md
AUDIO_MEM_CTRL -- requirements
Module: audio_mem_ctrl

Interface
REQ-001 SHALL have port bclk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port cmd_rec  input  1  single-cycle pulse; start recording.
REQ-004 SHALL have port cmd_play  input  1  single-cycle pulse; start playback.
REQ-005 SHALL have port cmd_stop  input  1  single-cycle pulse; abort current mode.
REQ-006 SHALL have port adc_valid  input  1  single-cycle pulse; adc_data holds a new sample.
REQ-007 SHALL have port adc_data  input  16  captured sample from ADC deserializer.
REQ-008 SHALL have port dac_req  input  1  single-cycle pulse; DAC requests next sample.
REQ-009 SHALL have port sram_rdata  input  16  SRAM read data.
REQ-010 SHALL have port sram_addr  output  18  SRAM address.
REQ-011 SHALL have port sram_wdata  output  16  SRAM write data.
REQ-012 SHALL have port sram_we_n  output  1  SRAM write strobe, active-low.
REQ-013 SHALL have port sram_oe_n  output  1  SRAM output enable, active-low.
REQ-014 SHALL have port dac_data  output  16  sample returned to DAC.
REQ-015 SHALL have port dac_valid  output  1  single-cycle pulse; dac_data updated.
REQ-016 SHALL have port mode  output  2  0 IDLE, 1 REC, 2 PLAY.
REQ-017 SHALL have port rec_len  output  19  samples stored by last recording.
REQ-018 SHALL have port overrun  output  1  sticky; sample or request dropped.

Function
REQ-019 SHALL implement FSM IDLE/REC/PLAY; command priority stop > rec > play when simultaneous.
REQ-020 SHALL accept cmd_rec/cmd_play only in IDLE; ignore them otherwise.
REQ-021 SHALL on IDLE->REC clear address pointer to 0, rec_len to 0 and overrun to 0.
REQ-022 SHALL in REC on adc_valid perform write: cycle 1 drive addr/wdata with we_n=1, cycle 2 we_n=0, then pointer+1 and rec_len+1.
REQ-023 SHALL, when write completes at address 18'h3FFFF, set rec_len=262144 and return to IDLE.
REQ-024 SHALL on IDLE->PLAY clear pointer to 0; if rec_len==0 remain IDLE.
REQ-025 SHALL in PLAY on dac_req drive oe_n=0 for 2 cycles, capture sram_rdata at end of cycle 2 into dac_data, pulse dac_valid the following cycle (3-cycle latency), pointer+1.
REQ-026 SHALL after reading address rec_len-1 return to IDLE.
REQ-027 SHALL drop adc_valid/dac_req arriving while an access is in progress and set overrun.
REQ-028 SHALL on cmd_stop complete any in-flight access, then enter IDLE; rec_len keeps count written.
REQ-029 SHALL never assert we_n=0 and oe_n=0 together; both 1 in IDLE.

Reset
REQ-030 SHALL on reset force mode=IDLE, pointer=0, sram_addr=0, sram_wdata=0, we_n=1, oe_n=1, dac_data=0, dac_valid=0, rec_len=0, overrun=0.
REQ-031 SHALL abort any in-flight access immediately on reset without completing it.

Configuration
REQ-032 SHALL with AUDIO_LOOP_PLAY_EN defined wrap playback pointer to 0 after rec_len-1 and stay in PLAY until cmd_stop; without it, behave per REQ-026.

Structure
REQ-033 SHALL place mode enum, ADDR_W=18, DATA_W=16, MEM_DEPTH=262144 in shared package audio_pkg.
REQ-034 SHALL isolate SRAM strobe sequencing in sub-module sram_access_seq (start, rd/wr, done).

Verification
REQ-035 SHALL test: cmd_rec, 4 adc_valid (0x1111..0x4444) -> writes to addr 0..3, we_n low 1 cycle each, rec_len=4.
REQ-036 SHALL test: then cmd_play, 4 dac_req -> dac_data 0x1111..0x4444, dac_valid 3 cycles after each req, then mode=IDLE.
REQ-037 SHALL test: cmd_rec and cmd_stop same cycle in IDLE -> mode stays IDLE, no write.
REQ-038 SHALL test: adc_valid one cycle after previous -> second sample dropped, overrun=1.
REQ-039 SHALL test: preload pointer near 18'h3FFFF, record -> final write at 0x3FFFF, rec_len=262144, mode=IDLE.
REQ-040 SHALL test: reset asserted mid-write -> next cycle we_n=1, mode=IDLE, rec_len=0.
